// File: rtl/hynoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hynoc_pkg
// Brief    : Shared ingress state encoding, flit layout and route-width helpers.
// Revision : 1.0
// ============================================================================
package hynoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SEND    = 2'd2,
    ST_DROP    = 2'd3
  } ingress_state_e;

  // Width of the source-route field; floor of 1 keeps degenerate configs legal.
  function automatic int route_width(input int nb_ports);
    return (nb_ports > 2) ? $clog2(nb_ports - 1) : 1;
  endfunction

  function automatic int stop_bit_idx(input int payload_width);
    return payload_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hynoc_route_rotate.sv
`default_nettype none
// ============================================================================
// Module   : hynoc_route_rotate
// Brief    : Rotates a header payload right so consumed route bits land on top.
// Revision : 1.0
// ============================================================================
module hynoc_route_rotate #(
  parameter int PAYLOAD_WIDTH = 32,
  parameter int ROUTE_WIDTH   = 2
) (
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  output logic [PAYLOAD_WIDTH-1:0] rotated_o
);

  assign rotated_o = {payload_i[ROUTE_WIDTH-1:0], payload_i[PAYLOAD_WIDTH-1:ROUTE_WIDTH]};

endmodule
`default_nettype wire

// File: rtl/hynoc_ingress.sv
`default_nettype none
// ============================================================================
// Module   : hynoc_ingress
// Brief    : Router input port: pops source-routed packets from the input FIFO
//            and streams them to the selected egress. HYNOC_INGRESS_DROP_EN
//            discards packets whose route field is out of range.
// Revision : 1.0
// ============================================================================
module hynoc_ingress
  import hynoc_pkg::*;
#(
  parameter int NB_PORTS      = 5,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 1,
  parameter int ROUTE_WIDTH   = route_width(NB_PORTS)
) (
  input  logic                  router_clk,
  input  logic                  router_srst,
  output logic                  rclk,
  output logic                  rsrst,
  output logic                  ren,
  input  logic [FLIT_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic [NB_PORTS-2:0]   to_egress_request,
  output logic [NB_PORTS-2:0]   to_egress_write,
  output logic [FLIT_WIDTH-1:0] to_egress_data,
  input  logic [NB_PORTS-2:0]   from_egress_grant,
  input  logic [NB_PORTS-2:0]   from_egress_afull,
  output logic                  dropped
);

  localparam int PRRA_WIDTH = NB_PORTS - 1;
  localparam int STOP_BIT   = stop_bit_idx(PAYLOAD_WIDTH);

  ingress_state_e          state_q;
  logic [ROUTE_WIDTH-1:0]  dest_q;
  logic                    first_q;
  logic [PRRA_WIDTH-1:0]   request_q;
  logic [PRRA_WIDTH-1:0]   write_q;
  logic [FLIT_WIDTH-1:0]   data_q;

  logic [ROUTE_WIDTH-1:0]   hdr_route;
  logic [ROUTE_WIDTH-1:0]   hdr_dest;
  logic                     hdr_in_range;
  logic [PRRA_WIDTH-1:0]    hdr_onehot;
  logic [PRRA_WIDTH-1:0]    dest_onehot;
  logic                     egress_ready;
  logic                     send_pop;
  logic                     pop_stop;
  logic [PAYLOAD_WIDTH-1:0] rotated;
  logic [FLIT_WIDTH-1:0]    out_flit;

  assign rclk  = router_clk;
  assign rsrst = router_srst;

  assign hdr_route    = rdata[ROUTE_WIDTH-1:0];
  assign hdr_in_range = (int'(hdr_route) < PRRA_WIDTH);
  // Out-of-range routes wrap onto the low egresses when they are not dropped.
  assign hdr_dest     = hdr_in_range ? hdr_route : hdr_route - ROUTE_WIDTH'(PRRA_WIDTH);
  assign hdr_onehot   = PRRA_WIDTH'(1) << hdr_dest;
  assign dest_onehot  = PRRA_WIDTH'(1) << dest_q;

  assign egress_ready = from_egress_grant[dest_q] & ~from_egress_afull[dest_q];
  assign send_pop     = (state_q == ST_SEND) & ~rempty & egress_ready;
  assign pop_stop     = rdata[STOP_BIT];

  hynoc_route_rotate #(
    .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
    .ROUTE_WIDTH   (ROUTE_WIDTH)
  ) u_rotate (
    .payload_i (rdata[PAYLOAD_WIDTH-1:0]),
    .rotated_o (rotated)
  );

  assign out_flit = first_q ? {pop_stop, rotated} : rdata;

`ifdef HYNOC_INGRESS_DROP_EN
  logic drop_pop;
  logic dropped_q;

  assign drop_pop = (state_q == ST_DROP) & ~rempty;
  assign ren      = ~router_srst & (send_pop | drop_pop);
  assign dropped  = dropped_q;
`else
  assign ren      = ~router_srst & send_pop;
  assign dropped  = 1'b0;
`endif

  assign to_egress_request = request_q;
  assign to_egress_write   = write_q;
  assign to_egress_data    = data_q;

  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      first_q   <= 1'b0;
      request_q <= '0;
      write_q   <= '0;
      data_q    <= '0;
`ifdef HYNOC_INGRESS_DROP_EN
      dropped_q <= 1'b0;
`endif
    end else begin
      write_q <= '0;
`ifdef HYNOC_INGRESS_DROP_EN
      dropped_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!rempty) begin
            dest_q  <= hdr_dest;
            first_q <= 1'b1;
`ifdef HYNOC_INGRESS_DROP_EN
            if (!hdr_in_range) begin
              state_q   <= ST_DROP;
              request_q <= '0;
            end else begin
              state_q   <= ST_REQUEST;
              request_q <= hdr_onehot;
            end
`else
            state_q   <= ST_REQUEST;
            request_q <= hdr_onehot;
`endif
          end else begin
            request_q <= '0;
          end
        end
        ST_REQUEST: begin
          request_q <= dest_onehot;
          if (from_egress_grant[dest_q]) begin
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Request stays up through the cycle that presents the stop write.
          request_q <= dest_onehot;
          if (send_pop) begin
            write_q <= dest_onehot;
            data_q  <= out_flit;
            first_q <= 1'b0;
            if (pop_stop) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          request_q <= '0;
`ifdef HYNOC_INGRESS_DROP_EN
          if (drop_pop && pop_stop) begin
            dropped_q <= 1'b1;
            first_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          request_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
